// File: rtl/adsr_sequencer.sv
// rtl/adsr_sequencer.sv - ADSR amplitude envelope sequencer stepped by sample strobes
module adsr_sequencer #(
    parameter int DIV_W = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_en,
    input  logic       gate,
    input  logic [7:0] amp_envelope,
    output logic [7:0] env_level,
    output logic [2:0] env_state,
    output logic       env_active,
    output logic       note_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       level_q, level_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       params_q, params_d;
    logic             gate_q;
    logic             active_q;
    logic             note_done_q, note_done_d;

    logic             rise, fall, step;
    logic [1:0]       rate_code;
    logic [7:0]       sus_level;

    // Terminal count of the divider: D-1 for D = 1, 4, 16, 64.
    function automatic logic [DIV_W-1:0] div_last(input logic [1:0] code);
        case (code)
            2'd0:    div_last = DIV_W'(0);
            2'd1:    div_last = DIV_W'(3);
            2'd2:    div_last = DIV_W'(15);
            default: div_last = DIV_W'(63);
        endcase
    endfunction

    function automatic logic [7:0] sustain_of(input logic [1:0] code);
        case (code)
            2'd0:    sustain_of = 8'd64;
            2'd1:    sustain_of = 8'd128;
            2'd2:    sustain_of = 8'd192;
            default: sustain_of = 8'd255;
        endcase
    endfunction

    assign rise      = gate & ~gate_q;
    assign fall      = ~gate & gate_q;
    assign sus_level = sustain_of(params_q[3:2]);

    always_comb begin
        case (state_q)
            S_ATTACK: rate_code = params_q[7:6];
            S_DECAY:  rate_code = params_q[5:4];
            default:  rate_code = params_q[1:0];
        endcase
    end

    assign step = sample_en && (div_q == div_last(rate_code));

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        div_d       = div_q;
        params_d    = params_q;
        note_done_d = 1'b0;
        if (rise) begin
            // Retrigger keeps the current level (legato).
            state_d  = S_ATTACK;
            params_d = amp_envelope;
            div_d    = '0;
        end else if (fall && (state_q == S_ATTACK || state_q == S_DECAY ||
                              state_q == S_SUSTAIN)) begin
            state_d = S_RELEASE;
            div_d   = '0;
        end else if (!fall) begin
            case (state_q)
                S_IDLE: level_d = 8'd0;
                S_ATTACK: begin
                    if (step) begin
                        div_d = '0;
                        if (level_q >= 8'd254) begin
                            level_d = 8'd255;
                            state_d = S_DECAY;
                        end else begin
                            level_d = level_q + 8'd1;
                        end
                    end else if (sample_en) begin
                        div_d = div_q + 1'b1;
                    end
                end
                S_DECAY: begin
                    if (level_q <= sus_level) begin
                        state_d = S_SUSTAIN;
                        level_d = sus_level;
                        div_d   = '0;
                    end else if (step) begin
                        div_d   = '0;
                        level_d = level_q - 8'd1;
                    end else if (sample_en) begin
                        div_d = div_q + 1'b1;
                    end
                end
                S_SUSTAIN: level_d = sus_level;
                S_RELEASE: begin
                    if (step) begin
                        div_d = '0;
                        if (level_q <= 8'd1) begin
                            level_d     = 8'd0;
                            state_d     = S_IDLE;
                            note_done_d = 1'b1;
                        end else begin
                            level_d = level_q - 8'd1;
                        end
                    end else if (sample_en) begin
                        div_d = div_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    level_d = 8'd0;
                    div_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            level_q     <= 8'd0;
            div_q       <= '0;
            params_q    <= 8'd0;
            gate_q      <= 1'b0;
            active_q    <= 1'b0;
            note_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            div_q       <= div_d;
            params_q    <= params_d;
            gate_q      <= gate;
            active_q    <= (state_d != S_IDLE);
            note_done_q <= note_done_d;
        end
    end

    assign env_level  = level_q;
    assign env_state  = state_q;
    assign env_active = active_q;
    assign note_done  = note_done_q;

endmodule

// File: tb/tb_adsr_sequencer.sv
// tb/tb_adsr_sequencer.sv - randomized self-checking bench for adsr_sequencer
module tb_adsr_sequencer;

    localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_en;
    logic       gate;
    logic [7:0] amp_envelope;
    logic [7:0] env_level;
    logic [2:0] env_state;
    logic       env_active;
    logic       note_done;

    int checks = 0;
    int errors = 0;
    int nd_pulses = 0;

    // Reference envelope: phase, level and strobes counted toward the next step.
    int m_ph, m_lvl, m_cnt, m_gq, m_nd;
    int m_atk, m_dec, m_sus, m_rel;

    always #5 clk = ~clk;

    adsr_sequencer #(.DIV_W(6)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_en    (sample_en),
        .gate         (gate),
        .amp_envelope (amp_envelope),
        .env_level    (env_level),
        .env_state    (env_state),
        .env_active   (env_active),
        .note_done    (note_done)
    );

    function automatic int div_of(input int code);
        return 1 << (2 * code);
    endfunction

    function automatic int sus_of(input int code);
        return (code == 3) ? 255 : 64 * (code + 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_lvl = 0; m_cnt = 0; m_gq = 0; m_nd = 0;
        m_atk = 0; m_dec = 0; m_sus = 64; m_rel = 0;
    endtask

    // Counts strobes in the current phase and reports whether this one completes a step.
    function automatic bit count_strobe(input int code);
        m_cnt++;
        if (m_cnt >= div_of(code)) begin
            m_cnt = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int g;
        bit rise, fall;
        g    = int'(gate);
        rise = (g == 1) && (m_gq == 0);
        fall = (g == 0) && (m_gq == 1);
        m_gq = g;
        m_nd = 0;
        if (rise) begin
            m_ph  = P_ATK;
            m_cnt = 0;
            m_atk = int'(amp_envelope[7:6]);
            m_dec = int'(amp_envelope[5:4]);
            m_sus = sus_of(int'(amp_envelope[3:2]));
            m_rel = int'(amp_envelope[1:0]);
        end else if (fall && (m_ph == P_ATK || m_ph == P_DEC || m_ph == P_SUS)) begin
            m_ph  = P_REL;
            m_cnt = 0;
        end else if (!fall) begin
            if (m_ph == P_IDLE) begin
                m_lvl = 0;
            end else if (m_ph == P_ATK) begin
                if (sample_en && count_strobe(m_atk)) begin
                    m_lvl = (m_lvl + 1 > 255) ? 255 : m_lvl + 1;
                    if (m_lvl == 255) m_ph = P_DEC;
                end
            end else if (m_ph == P_DEC) begin
                if (m_lvl <= m_sus) begin
                    m_ph  = P_SUS;
                    m_lvl = m_sus;
                    m_cnt = 0;
                end else if (sample_en && count_strobe(m_dec)) begin
                    m_lvl = m_lvl - 1;
                end
            end else if (m_ph == P_SUS) begin
                m_lvl = m_sus;
            end else if (m_ph == P_REL) begin
                if (sample_en && count_strobe(m_rel)) begin
                    m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
                    if (m_lvl == 0) begin
                        m_ph = P_IDLE;
                        m_nd = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) model_reset();
            else model_step();
            #1;
            check("level", int'(env_level), m_lvl);
            check("state", int'(env_state), m_ph);
            check("active", int'(env_active), (m_ph != P_IDLE) ? 1 : 0);
            check("note_done", int'(note_done), m_nd);
            if (note_done) nd_pulses++;
        end
    end

    task automatic step_cyc(input logic g, input logic se, input logic [7:0] env);
        @(negedge clk);
        gate = g; sample_en = se; amp_envelope = env;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nd0;
        reset_n = 1'b0; gate = 1'b0; sample_en = 1'b0; amp_envelope = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        step_cyc(1'b0, 1'b1, 8'hFF);
        check("rst_level", int'(env_level), 0);
        check("rst_state", int'(env_state), 0);
        check("rst_active", int'(env_active), 0);

        // Full envelope, sustain 192; rise coincides with a strobe in IDLE.
        step_cyc(1'b1, 1'b1, 8'b00_00_10_00);
        check("rise_idle_state", int'(env_state), 1);
        check("rise_idle_level", int'(env_level), 0);
        repeat (254) step_cyc(1'b1, 1'b1, 8'b00_00_10_00);
        check("atk254_level", int'(env_level), 254);
        step_cyc(1'b1, 1'b1, 8'b00_00_10_00);
        check("atk255_level", int'(env_level), 255);
        check("atk255_state", int'(env_state), 2);
        repeat (63) step_cyc(1'b1, 1'b1, 8'b00_00_10_00);
        check("dec_level", int'(env_level), 192);
        check("dec_state", int'(env_state), 2);
        step_cyc(1'b1, 1'b1, 8'b00_00_10_00);
        check("sus_state", int'(env_state), 3);
        repeat (10) step_cyc(1'b1, 1'b1, 8'hFF);
        check("sus_hold_level", int'(env_level), 192);
        nd0 = nd_pulses;
        step_cyc(1'b0, 1'b1, 8'hFF);
        check("rel_state", int'(env_state), 4);
        check("rel_level", int'(env_level), 192);
        repeat (191) step_cyc(1'b0, 1'b1, 8'hFF);
        check("rel_level1", int'(env_level), 1);
        step_cyc(1'b0, 1'b1, 8'hFF);
        check("done_state", int'(env_state), 0);
        check("done_pulse", int'(note_done), 1);
        step_cyc(1'b0, 1'b1, 8'hFF);
        check("done_low", int'(note_done), 0);
        check("done_count", nd_pulses - nd0, 1);

        // Divider, attack code 2.
        step_cyc(1'b1, 1'b1, 8'b10_00_00_00);
        repeat (15) step_cyc(1'b1, 1'b1, 8'h00);
        check("div_15", int'(env_level), 0);
        step_cyc(1'b1, 1'b1, 8'h00);
        check("div_16", int'(env_level), 1);
        repeat (15) step_cyc(1'b1, 1'b1, 8'h00);
        check("div_31", int'(env_level), 1);
        step_cyc(1'b1, 1'b1, 8'h00);
        check("div_32", int'(env_level), 2);
        repeat (5) step_cyc(1'b0, 1'b1, 8'h00);
        check("div_idle", int'(env_state), 0);

        // Early release at level 100.
        step_cyc(1'b1, 1'b1, 8'h00);
        repeat (100) step_cyc(1'b1, 1'b1, 8'h00);
        check("early_level", int'(env_level), 100);
        step_cyc(1'b0, 1'b1, 8'h00);
        check("early_state", int'(env_state), 4);
        check("early_level_kept", int'(env_level), 100);
        step_cyc(1'b0, 1'b1, 8'h00);
        check("early_dec", int'(env_level), 99);

        // Retrigger in RELEASE at 50 with new parameters, then sustain 255.
        repeat (49) step_cyc(1'b0, 1'b1, 8'h00);
        check("retrig_pre", int'(env_level), 50);
        nd0 = nd_pulses;
        step_cyc(1'b1, 1'b1, 8'b01_00_11_01);
        check("retrig_state", int'(env_state), 1);
        check("retrig_level", int'(env_level), 50);
        repeat (3) step_cyc(1'b1, 1'b1, 8'h00);
        check("retrig_rate3", int'(env_level), 50);
        step_cyc(1'b1, 1'b1, 8'h00);
        check("retrig_rate4", int'(env_level), 51);
        check("retrig_no_done", nd_pulses - nd0, 0);
        repeat (816) step_cyc(1'b1, 1'b1, 8'h00);
        check("s3_dec_state", int'(env_state), 2);
        check("s3_dec_level", int'(env_level), 255);
        step_cyc(1'b1, 1'b1, 8'h00);
        check("s3_sus_state", int'(env_state), 3);
        check("s3_sus_level", int'(env_level), 255);

        repeat (1030) step_cyc(1'b0, 1'b1, 8'h00);
        check("s3_idle", int'(env_state), 0);

        // Reset mid-attack at level 37, gate held through reset.
        step_cyc(1'b1, 1'b1, 8'h00);
        repeat (37) step_cyc(1'b1, 1'b1, 8'h00);
        check("mid_level", int'(env_level), 37);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_level", int'(env_level), 0);
        check("async_state", int'(env_state), 0);
        check("async_active", int'(env_active), 0);
        check("async_done", int'(note_done), 0);
        @(negedge clk);
        reset_n = 1'b1; gate = 1'b1; sample_en = 1'b1;
        @(posedge clk);
        #2;
        check("post_rst_state", int'(env_state), 1);
        check("post_rst_level", int'(env_level), 0);
        step_cyc(1'b1, 1'b1, 8'h00);
        check("post_rst_step", int'(env_level), 1);

        // Random notes against the reference model.
        for (int n = 0; n < 14; n++) begin
            logic [7:0] env;
            int hold, rest, dens;
            env  = 8'($urandom);
            hold = $urandom_range(1, 1400);
            rest = $urandom_range(1, 1400);
            dens = $urandom_range(1, 4);
            for (int c = 0; c < hold; c++)
                step_cyc(1'b1, ($urandom_range(0, 3) < dens), (c % 97 == 5) ? 8'($urandom) : env);
            for (int c = 0; c < rest; c++)
                step_cyc(1'b0, ($urandom_range(0, 3) < dens), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
